// File: rtl/dreg_wbq.sv
// Writeback queue: merges load-unit and execute-unit results into one in-order
// register-file write port, with per-register pending tracking.
module dreg_wbq #(
    parameter int BITNESS = 32,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [4:0]                   ld_addr,
    input  logic [BITNESS-1:0]           ld_data,
    input  logic [1:0]                   ld_size,
    input  logic                         ex_valid,
    output logic                         ex_ready,
    input  logic [4:0]                   ex_addr,
    input  logic [BITNESS-1:0]           ex_data,
    input  logic [1:0]                   ex_size,
    output logic                         w,
    output logic [4:0]                   wa,
    output logic [BITNESS-1:0]           wval,
    output logic [BITNESS-1:0]           mask,
    output logic [31:0]                  pending,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0]         addr;
        logic [BITNESS-1:0] data;
        logic [1:0]         size;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          ld_push, ex_push;
    logic [1:0]    n_push;
    entry_t        head;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input int inc);
        int s;
        s = int'(p) + inc;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    function automatic logic [BITNESS-1:0] size_mask(input logic [1:0] size);
        logic [BITNESS-1:0] m;
        int                 width;
        width = 8 << size;
        m = '0;
        for (int i = 0; i < BITNESS; i++) m[i] = (i < width);
        return m;
    endfunction

    // Ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        ld_ready = !flush && (count < CW'(DEPTH));
        ex_ready = !flush && ((count < CW'(DEPTH-1)) || ((count == CW'(DEPTH-1)) && !ld_valid));
        ld_push  = ld_valid && ld_ready;
        ex_push  = ex_valid && ex_ready;
        n_push   = 2'(ld_push) + 2'(ex_push);
        w        = (count != '0) && !flush;
        head     = mem[rd_ptr];
        wa       = '0;
        wval     = '0;
        mask     = '0;
        if (count != '0) begin
            wa   = head.addr;
            wval = head.data;
            mask = size_mask(head.size);
        end
    end

    // Occupied slots are the count entries starting at rd_ptr, modulo DEPTH.
    always_comb begin
        int off;
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = i - int'(rd_ptr);
            if (off < 0) off = off + DEPTH;
            if (off < int'(count)) begin
                pending[mem[i].addr] = 1'b1;
                if (!mem[i].addr[4]) pending[{1'b1, mem[i].addr[3:0]}] = 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; only pointers and count define which slots are live.
    always_ff @(posedge clk) begin
        if (ld_push) mem[wr_ptr] <= '{addr: ld_addr, data: ld_data, size: ld_size};
        if (ex_push) mem[ld_push ? wrap_add(wr_ptr, 1) : wr_ptr] <= '{addr: ex_addr, data: ex_data, size: ex_size};
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wrap_add(wr_ptr, int'(n_push));
            rd_ptr <= wrap_add(rd_ptr, int'(w));
            count  <= count + CW'(n_push) - CW'(w);
        end
    end

endmodule
